pp_stream_gen: RTL
==================

// Module: pp_stream_gen
// PURPOSE
//  Upstream feeder for the multiplier's per-column shift_register stage. Takes two N-bit
//  operands, generates the AND-array partial products and streams them one bit per column
//  per cycle over N cycles, so each column register holds exactly its partial-product bits
//  when done pulses. The compressor behind the shift registers then presents the 2N-bit
//  product on dst0..dst(2N-1).
// PARAMETERS
//  N    29   operand width; columns = 2N-1; max column height h(k) = min(k+1, 2N-1-k)
//  CW   $clog2(N)   step-counter width (derived, not overridable)
// PORTS
//  clk     in   1       rising-edge clock
//  rst     in   1       async active-high reset
//  start   in   1       request; accepted only when state != STREAM
//  a       in   N       multiplicand, sampled on accepting edge
//  b       in   N       multiplier, sampled on accepting edge
//  pp_bit  out  2N-1    bit k drives column k serial input (src<k>_)
//  busy    out  1       high while STREAM
//  done    out  1       one-cycle pulse: all columns fully loaded
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, step=0, a_q=b_q=0, pp_bit=0, busy=0, done=0.
//  - FSM: IDLE -start-> STREAM; STREAM -(step==N-1)-> DONE; DONE -start-> STREAM, else -> IDLE.
//  - Accept edge E0 latches a_q,b_q and step=0; pp_bit/busy are registered and valid from E0 on.
//  - Step t (0..N-1), column k: pad = N-h(k); imin = max(0,k-N+1).
//    t < pad -> pp_bit[k]=0 (pushed out the top of the column register);
//    t >= pad -> r=t-pad, i=imin+r, pp_bit[k]=a_q[i] & b_q[k-i].
//  - Downstream shifts on edges E1..EN; after EN column k holds r=0 at MSB, r=h(k)-1 at LSB.
//  - done=1 for exactly the cycle after EN (state DONE); pp_bit=0, busy=0 in DONE and IDLE.
//  - start while STREAM: ignored, operands not re-sampled, no error flag.
//  - start in DONE: back-to-back, new stream starts at next edge with no idle gap.
//  - rst mid-stream: everything returns to reset values immediately; partial stream abandoned,
//    done not pulsed; a new start is required.
//  - Column heights sum to N*N; every (i,j) pair emitted exactly once per run.
// STRUCTURE
//  - Shared package mul_pkg: localparam N, function col_height(k), function col_imin(k),
//    FSM state enum {IDLE, STREAM, DONE}. Also consumed by the shift_register/compressor benches.
//  - One sub-module: pp_col_sel (per-column combinational mux, params N,K; in a_q,b_q,step;
//    out bit), instantiated 2N-1 times via generate. FSM, counter, and output register stay
//    in the top module.
// TESTING (N=29, pp_stream_gen -> shift_register -> compressor)
//  1. a=1,b=1 -> pp_bit[0]=1 only at step 28, all else 0; after done dst0=1, dst1..dst57=0.
//  2. a=b=29'h1FFFFFFF -> done 29 cycles after accept; {dst57..dst0}=58'h3FFFFFFC0000001.
//  3. a=29'h1, b=29'h10000000 -> pp_bit[28]=1 at step 0 only; product bit 28 set.
//  4. Random 1000 operand pairs, back-to-back starts in DONE -> product==a*b each run, no gap.
//  5. start pulsed at steps 5 and 20 with different a,b -> ignored; result matches first pair.
//  6. rst asserted at step 10 -> pp_bit=0, busy=0 same cycle, no done; next start gives correct product.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared multiplier definitions: operand width, column geometry of the AND array,
// and the partial-product streamer FSM states.
package mul_pkg;

  localparam int N  = 29;
  localparam int CW = $clog2(N);
  localparam int NC = 2 * N - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int col_height(input int k);
    return (k + 1 < NC - k) ? k + 1 : NC - k;
  endfunction

  function automatic int col_imin(input int k);
    return (k - N + 1 > 0) ? k - N + 1 : 0;
  endfunction

  // Short columns are front-padded with zeros so every column finishes on the same step.
  function automatic int col_pad(input int k);
    return N - col_height(k);
  endfunction

endpackage

// File: rtl/pp_col_sel.sv
// Per-column partial-product selector: picks a[i] & b[K-i] for the row that the
// current step maps to, or 0 while the column is still in its zero padding.
module pp_col_sel #(
  parameter int N = mul_pkg::N,
  parameter int K = 0
) (
  input  logic [N-1:0]         a_q,
  input  logic [N-1:0]         b_q,
  input  logic [$clog2(N)-1:0] step,
  output logic                 o_bit
);

  localparam int CW   = $clog2(N);
  localparam int H    = mul_pkg::col_height(K);
  localparam int PAD  = mul_pkg::col_pad(K);
  localparam int IMIN = mul_pkg::col_imin(K);

  logic [H-1:0] w_hit;

  // Row r of this column is emitted on step PAD+r; all indices are elaboration constants.
  for (genvar r = 0; r < H; r++) begin : g_row
    assign w_hit[r] = (step == CW'(PAD + r)) & a_q[IMIN + r] & b_q[K - IMIN - r];
  end

  assign o_bit = |w_hit;

endmodule

// File: rtl/pp_stream_gen.sv
// Streams the AND-array partial products of a*b one bit per column per cycle over
// N cycles into the per-column shift registers, then pulses done for one cycle.
module pp_stream_gen
  import mul_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic [NC-1:0] pp_bit,
  output logic          busy,
  output logic          done,
  output state_t        dbg_state
);

  state_t          r_state;
  logic [CW-1:0]   r_step;
  logic [N-1:0]    r_a_q;
  logic [N-1:0]    r_b_q;
  logic [NC-1:0]   r_pp_bit;
  logic            r_busy;
  logic            r_done;

  logic            w_accept;
  logic [N-1:0]    w_a_src;
  logic [N-1:0]    w_b_src;
  logic [CW-1:0]   w_step_src;
  logic [NC-1:0]   w_pp;

  // Handshake: start is a level request with no ready; it is taken on any edge where
  // the FSM is not in STREAM (IDLE or DONE) and silently dropped while streaming.
  assign w_accept = start && (r_state != STREAM);

  // The column muxes see the values the registers are about to take, so pp_bit is
  // already valid for step 0 in the cycle right after the accepting edge.
  assign w_a_src    = w_accept ? a  : r_a_q;
  assign w_b_src    = w_accept ? b  : r_b_q;
  assign w_step_src = w_accept ? '0 : r_step + 1'b1;

  for (genvar k = 0; k < NC; k++) begin : g_col
    pp_col_sel #(
      .N (N),
      .K (k)
    ) u_col (
      .a_q   (w_a_src),
      .b_q   (w_b_src),
      .step  (w_step_src),
      .o_bit (w_pp[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_step   <= '0;
      r_a_q    <= '0;
      r_b_q    <= '0;
      r_pp_bit <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        STREAM: begin
          if (r_step == CW'(N - 1)) begin
            r_state  <= DONE;
            r_step   <= '0;
            r_pp_bit <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_step   <= w_step_src;
            r_pp_bit <= w_pp;
          end
        end
        default: begin
          if (w_accept) begin
            r_state  <= STREAM;
            r_step   <= '0;
            r_a_q    <= a;
            r_b_q    <= b;
            r_pp_bit <= w_pp;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end else begin
            r_state  <= IDLE;
            r_step   <= '0;
            r_pp_bit <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign pp_bit    = r_pp_bit;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule
